// File: rtl/midi_note_decoder.sv
// MIDI channel-voice parser for a single voice: decodes note-on/off on CHANNEL into note/velocity/gate and one-cycle pulses.
// Define RUNNING_STATUS_EN to accept data bytes under running status after a completed message.
module midi_note_decoder #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       new_note_pulse,
  output logic       release_note_pulse,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_KEY,
    WAIT_VEL
  } state_t;

  state_t     state, state_d;
  logic       kind_on, kind_on_d;
  logic [6:0] key, key_d;
  logic [6:0] note_d, velocity_d;
  logic       gate_d, new_d, rel_d;
`ifdef RUNNING_STATUS_EN
  logic       rs_valid, rs_valid_d;
`endif

  logic is_realtime, is_status, is_ours;
  assign is_realtime = rx_valid && (rx_data >= 8'hF8);
  assign is_status   = rx_data[7];
  assign is_ours     = (rx_data[7:5] == 3'b100) && (rx_data[3:0] == CHANNEL);

  always_comb begin
    state_d    = state;
    kind_on_d  = kind_on;
    key_d      = key;
    note_d     = note;
    velocity_d = velocity;
    gate_d     = gate;
    new_d      = 1'b0;
    rel_d      = 1'b0;
`ifdef RUNNING_STATUS_EN
    rs_valid_d = rs_valid;
`endif
    if (rx_valid && !is_realtime) begin
      if (is_status) begin
        if (is_ours) begin
          kind_on_d = rx_data[4];
          state_d   = WAIT_KEY;
`ifdef RUNNING_STATUS_EN
          rs_valid_d = 1'b1;
`endif
        end else begin
          state_d = IDLE;
`ifdef RUNNING_STATUS_EN
          rs_valid_d = 1'b0;
`endif
        end
      end else begin
        case (state)
          IDLE: begin
`ifdef RUNNING_STATUS_EN
            if (rs_valid) begin
              key_d   = rx_data[6:0];
              state_d = WAIT_VEL;
            end
`endif
          end
          WAIT_KEY: begin
            key_d   = rx_data[6:0];
            state_d = WAIT_VEL;
          end
          WAIT_VEL: begin
            // Note-on with velocity 0 is treated exactly like note-off.
            if (kind_on && (rx_data[6:0] != 7'd0)) begin
              note_d     = key;
              velocity_d = rx_data[6:0];
              gate_d     = 1'b1;
              new_d      = 1'b1;
            end else if (gate && (key == note)) begin
              gate_d = 1'b0;
              rel_d  = 1'b1;
            end
`ifdef RUNNING_STATUS_EN
            state_d = WAIT_KEY;
`else
            state_d = IDLE;
`endif
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      kind_on            <= 1'b0;
      key                <= '0;
      note               <= '0;
      velocity           <= '0;
      gate               <= 1'b0;
      new_note_pulse     <= 1'b0;
      release_note_pulse <= 1'b0;
`ifdef RUNNING_STATUS_EN
      rs_valid           <= 1'b0;
`endif
    end else begin
      state              <= state_d;
      kind_on            <= kind_on_d;
      key                <= key_d;
      note               <= note_d;
      velocity           <= velocity_d;
      gate               <= gate_d;
      new_note_pulse     <= new_d;
      release_note_pulse <= rel_d;
`ifdef RUNNING_STATUS_EN
      rs_valid           <= rs_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Self-checking bench for midi_note_decoder: directed scenarios plus randomized byte streams against a message-level model.
module tb_midi_note_decoder;
  localparam logic [3:0] CH = 4'd0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       new_note_pulse, release_note_pulse, gate;
  logic [6:0] note, velocity;

  midi_note_decoder #(.CHANNEL(CH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .new_note_pulse(new_note_pulse), .release_note_pulse(release_note_pulse),
    .note(note), .velocity(velocity), .gate(gate)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Message-level model: m_kind is the active status (-1 none, 0 off, 1 on), m_q collects data bytes.
  int         m_kind;
  logic [6:0] m_q[$];
  logic       e_new, e_rel, e_gate;
  logic [6:0] e_note, e_vel;

  task automatic m_reset();
    m_kind = -1;
    m_q.delete();
    e_new = 0; e_rel = 0; e_gate = 0; e_note = '0; e_vel = '0;
  endtask

  task automatic m_step(input logic [7:0] b);
    logic [6:0] k, v;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_q.delete();
      if ((b[7:4] == 4'h9 || b[7:4] == 4'h8) && b[3:0] == CH) m_kind = (b[7:4] == 4'h9) ? 1 : 0;
      else m_kind = -1;
      return;
    end
    if (m_kind < 0) return;
    m_q.push_back(b[6:0]);
    if (m_q.size() == 2) begin
      k = m_q[0];
      v = m_q[1];
      m_q.delete();
      if (m_kind == 1 && v != 0) begin
        e_note = k; e_vel = v; e_gate = 1; e_new = 1;
      end else if (e_gate && k == e_note) begin
        e_gate = 0; e_rel = 1;
      end
`ifndef RUNNING_STATUS_EN
      m_kind = -1;
`endif
    end
  endtask

  // One clock: drive a byte (or idle with garbage data), advance the model, settle after the edge.
  task automatic put(input logic v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    e_new = 0; e_rel = 0;
    if (v) m_step(b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; rx_valid = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    n_tests++;
    if ({new_note_pulse, release_note_pulse, gate, note, velocity} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset: got new=%b rel=%b gate=%b note=%h vel=%h, expected all zero",
               new_note_pulse, release_note_pulse, gate, note, velocity);
    end
    rst_n = 1;
    m_reset();
  endtask

  task automatic test_note_on_off();
    logic [7:0] seq[9] = '{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h40, 8'h80, 8'h3E, 8'h40};
    do_reset();
    foreach (seq[i]) begin
      put(1, seq[i]);
      n_tests++;
      if ({new_note_pulse, release_note_pulse, gate, note, velocity} !== {e_new, e_rel, e_gate, e_note, e_vel}) begin
        n_fail++;
        $display("FAIL on_off byte%0d: got new=%b rel=%b gate=%b note=%h vel=%h, expected new=%b rel=%b gate=%b note=%h vel=%h",
                 i, new_note_pulse, release_note_pulse, gate, note, velocity, e_new, e_rel, e_gate, e_note, e_vel);
      end
      if (i == 2) begin
        n_tests++;
        if ({new_note_pulse, gate, note, velocity} !== {1'b1, 1'b1, 7'h3C, 7'h64}) begin
          n_fail++;
          $display("FAIL on_first: got new=%b gate=%b note=%h vel=%h, expected 1 1 3c 64", new_note_pulse, gate, note, velocity);
        end
        put(0, 8'h00);
        n_tests++;
        if (new_note_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL on_pulse_width: got new=%b, expected 0", new_note_pulse);
        end
      end
      if (i == 5) begin
        n_tests++;
        if ({release_note_pulse, gate, note} !== {1'b1, 1'b0, 7'h3C}) begin
          n_fail++;
          $display("FAIL off_match: got rel=%b gate=%b note=%h, expected 1 0 3c", release_note_pulse, gate, note);
        end
      end
      if (i == 8) begin
        n_tests++;
        if ({new_note_pulse, release_note_pulse} !== 2'b00) begin
          n_fail++;
          $display("FAIL off_nomatch: got new=%b rel=%b, expected 0 0", new_note_pulse, release_note_pulse);
        end
      end
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] seq[9] = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h40, 8'h7F, 8'h90, 8'h3C, 8'h00};
    int news = 0;
    do_reset();
    foreach (seq[i]) begin
      put(1, seq[i]);
      if (new_note_pulse === 1'b1) news++;
      n_tests++;
      if ({new_note_pulse, release_note_pulse, gate, note, velocity} !== {e_new, e_rel, e_gate, e_note, e_vel}) begin
        n_fail++;
        $display("FAIL retrig byte%0d: got new=%b rel=%b gate=%b note=%h vel=%h, expected new=%b rel=%b gate=%b note=%h vel=%h",
                 i, new_note_pulse, release_note_pulse, gate, note, velocity, e_new, e_rel, e_gate, e_note, e_vel);
      end
    end
    n_tests++;
    if (news != 2 || gate !== 1'b1 || note !== 7'h40 || velocity !== 7'h7F) begin
      n_fail++;
      $display("FAIL retrig_final: got pulses=%0d gate=%b note=%h vel=%h, expected 2 1 40 7f", news, gate, note, velocity);
    end
  endtask

  task automatic test_running_status();
    logic [7:0] seq[5] = '{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00};
    int news = 0, rels = 0;
    do_reset();
    foreach (seq[i]) begin
      put(1, seq[i]);
      if (new_note_pulse === 1'b1) news++;
      if (release_note_pulse === 1'b1) rels++;
      n_tests++;
      if ({new_note_pulse, release_note_pulse, gate, note, velocity} !== {e_new, e_rel, e_gate, e_note, e_vel}) begin
        n_fail++;
        $display("FAIL runstat byte%0d: got new=%b rel=%b gate=%b note=%h vel=%h, expected new=%b rel=%b gate=%b note=%h vel=%h",
                 i, new_note_pulse, release_note_pulse, gate, note, velocity, e_new, e_rel, e_gate, e_note, e_vel);
      end
    end
    n_tests++;
`ifdef RUNNING_STATUS_EN
    if (news != 1 || rels != 1 || gate !== 1'b0) begin
`else
    if (news != 1 || rels != 0 || gate !== 1'b1) begin
`endif
      n_fail++;
      $display("FAIL runstat_final: got new_pulses=%0d rel_pulses=%0d gate=%b", news, rels, gate);
    end
  endtask

  task automatic test_realtime_channel();
    logic [7:0] seq[14] = '{8'h90, 8'h3C, 8'hF8, 8'h64, 8'h91, 8'h3E, 8'h64,
                           8'h90, 8'h3E, 8'hB0, 8'h64, 8'h3E, 8'h64, 8'hFE};
    int news = 0;
    do_reset();
    foreach (seq[i]) begin
      put(1, seq[i]);
      if (new_note_pulse === 1'b1) news++;
      n_tests++;
      if ({new_note_pulse, release_note_pulse, gate, note, velocity} !== {e_new, e_rel, e_gate, e_note, e_vel}) begin
        n_fail++;
        $display("FAIL rt_chan byte%0d: got new=%b rel=%b gate=%b note=%h vel=%h, expected new=%b rel=%b gate=%b note=%h vel=%h",
                 i, new_note_pulse, release_note_pulse, gate, note, velocity, e_new, e_rel, e_gate, e_note, e_vel);
      end
    end
    n_tests++;
    if (news != 1 || note !== 7'h3C || velocity !== 7'h64) begin
      n_fail++;
      $display("FAIL rt_chan_final: got pulses=%0d note=%h vel=%h, expected 1 3c 64", news, note, velocity);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    put(1, 8'h90);
    put(1, 8'h3C);
    do_reset();
    put(1, 8'h64);
    put(0, 8'h00);
    n_tests++;
    if ({new_note_pulse, release_note_pulse, gate, note, velocity} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got new=%b rel=%b gate=%b note=%h vel=%h, expected all zero",
               new_note_pulse, release_note_pulse, gate, note, velocity);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[6] = '{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h00};
    int t_new = -1, t_rel = -1, cyc = 0;
    do_reset();
    foreach (seq[i]) begin
      put(1, seq[i]);
      cyc++;
      if (new_note_pulse === 1'b1) t_new = cyc;
      if (release_note_pulse === 1'b1) t_rel = cyc;
    end
    put(0, 8'h00);
    n_tests++;
    if (t_new != 3 || t_rel != 6) begin
      n_fail++;
      $display("FAIL back_to_back: got new at cycle %0d rel at cycle %0d, expected 3 and 6", t_new, t_rel);
    end
  endtask

  task automatic test_random();
    logic [7:0] others[5] = '{8'h91, 8'hB0, 8'hF8, 8'hFE, 8'hC0};
    logic [7:0] keys[3] = '{8'h3C, 8'h3E, 8'h40};
    logic [7:0] b;
    int r;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'h90;
      else if (r == 2) b = 8'h80;
      else if (r == 3) b = others[$urandom_range(0, 4)];
      else if (r < 7) b = keys[$urandom_range(0, 2)];
      else if (r == 7) b = 8'h00;
      else b = 8'($urandom_range(0, 127));
      put($urandom_range(0, 3) != 0, b);
      n_tests++;
      if ({new_note_pulse, release_note_pulse, gate, note, velocity} !== {e_new, e_rel, e_gate, e_note, e_vel}) begin
        n_fail++;
        $display("FAIL random step%0d: got new=%b rel=%b gate=%b note=%h vel=%h, expected new=%b rel=%b gate=%b note=%h vel=%h",
                 n, new_note_pulse, release_note_pulse, gate, note, velocity, e_new, e_rel, e_gate, e_note, e_vel);
      end
      if (new_note_pulse === 1'b1 && release_note_pulse === 1'b1) begin
        n_fail++;
        $display("FAIL pulse_exclusive step%0d: got both pulses high, expected at most one", n);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_note_on_off();
    test_retrigger();
    test_running_status();
    test_realtime_channel();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_note_decoder.md
MIDI_NOTE_DECODER -- requirements
Module: midi_note_decoder

Interface
REQ-001 The block SHALL have one parameter: CHANNEL, default 4'd0, the MIDI channel (0-15) the voice responds to.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rx_valid  input  1  one-cycle strobe indicating a received UART byte; may assert on consecutive cycles.
REQ-005 rx_data  input  8  MIDI byte, valid when rx_valid=1.
REQ-006 new_note_pulse  output  1  one-cycle pulse on an accepted note-on; drives the envelope stage's new-note input.
REQ-007 release_note_pulse  output  1  one-cycle pulse on an accepted note-off; drives the envelope stage's release input.
REQ-008 note  output  7  key number of the current note.
REQ-009 velocity  output  7  velocity of the current note.
REQ-010 gate  output  1  high while the current note is held.

Function
REQ-011 Parser states SHALL be IDLE, WAIT_KEY and WAIT_VEL; rx_data is ignored when rx_valid=0.
REQ-012 Real-time bytes 0xF8-0xFF SHALL be ignored, with no change to state or running status, in every state.
REQ-013 Status byte 0x9n or 0x8n with n==CHANNEL SHALL store the kind (ON/OFF) as running status and go to WAIT_KEY, from any state, aborting any partial message.
REQ-014 Any other status byte (0x80-0xF7 other than REQ-013) SHALL clear running status and go to IDLE.
REQ-015 Data byte (bit7=0) in WAIT_KEY SHALL latch rx_data[6:0] as pending key and go to WAIT_VEL.
REQ-016 Data byte in WAIT_VEL SHALL complete the message with rx_data[6:0] as pending velocity.
REQ-017 Completed ON with velocity>0: note<=key, velocity<=vel, gate<=1, new_note_pulse=1; this SHALL apply even if gate is already 1 (retrigger, last-note priority).
REQ-018 Completed ON with velocity=0, or completed OFF (velocity ignored): if gate=1 and key==note, then gate<=0 and release_note_pulse=1; otherwise no output change.
REQ-019 Note and velocity SHALL hold after release; only an accepted note-on updates them.
REQ-020 Pulse latency SHALL be exactly one clock: a pulse is high in the cycle after the rx_valid edge carrying the final data byte, for exactly one cycle.
REQ-021 new_note_pulse and release_note_pulse SHALL never be high in the same cycle.
REQ-022 Back-to-back messages on consecutive rx_valid cycles SHALL each produce their pulse with no loss.

Reset
REQ-023 While rst_n=0: state=IDLE, running status cleared, pending key/velocity=0, note=0, velocity=0, gate=0, both pulses=0.
REQ-024 Reset asserted mid-message SHALL discard the partial message; the first data byte after release with no status byte is handled per REQ-025/026 as IDLE.

Configuration
REQ-025 With RUNNING_STATUS_EN defined: after a completed message the parser SHALL go to WAIT_KEY; a data byte in IDLE while running status is valid SHALL be treated as a key byte (go to WAIT_VEL).
REQ-026 Without RUNNING_STATUS_EN: after a completed message the parser SHALL go to IDLE; data bytes in IDLE SHALL be ignored; running status storage may be absent.

Verification
REQ-027 CHANNEL=0: bytes 90 3C 64 -> next cycle new_note_pulse=1 for one cycle, note=0x3C, velocity=0x64, gate=1.
REQ-028 After REQ-027: 80 3C 40 -> release_note_pulse one cycle, gate=0, note stays 0x3C; then 80 3E 40 -> no pulse.
REQ-029 90 3C 64 then 90 40 7F -> two new_note_pulses, note=0x40; then 90 3C 00 -> no release (key mismatch), gate=1.
REQ-030 Running status: 90 3C 64 3C 00 -> with RUNNING_STATUS_EN new_note_pulse then release_note_pulse, gate=0; without the macro only new_note_pulse, gate=1.
REQ-031 90 3C F8 64 (clock byte inserted) -> new_note_pulse, velocity=0x64; 91 3C 64 (channel 1) -> no pulse; 90 3C B0 64 -> no pulse, state IDLE.
REQ-032 90 3C then rst_n low for 2 cycles, then 64 -> no pulse, all outputs 0; bytes on consecutive cycles 90 3C 64 80 3C 00 -> new pulse then release pulse exactly 3 cycles apart.
